// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad constants and priority encoder helper
package keypad_pkg;

  localparam int NUM_KEYS = 10;
  localparam int BCD_W    = 4;

  // Highest set bit wins, so key 9 has top priority.
  function automatic logic [BCD_W-1:0] highest_key(input logic [NUM_KEYS-1:0] keys);
    logic [BCD_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) idx = BCD_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/clk_div_1hz.sv
// rtl/clk_div_1hz.sv - divides clk down to a 50% duty 1 Hz square wave
module clk_div_1hz #(
  parameter int CLK_HZ = 50
) (
  input  logic clk,
  input  logic rst,
  output logic pgt_1Hz
);

  localparam int HALF = CLK_HZ / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] TERM = CW'(HALF - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      pgt_1Hz <= 1'b0;
    end else if (count == TERM) begin
      count   <= '0;
      pgt_1Hz <= ~pgt_1Hz;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - keypad to BCD encoder with load strobe; KEY_DEBOUNCE_EN adds debounce
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int CLK_HZ          = 50,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                enablen,
  output logic [BCD_W-1:0]    D,
  output logic                loadn,
  output logic                pgt_1Hz
);

  if (DEBOUNCE_CYCLES < 1 || CLK_HZ < 2 || (CLK_HZ % 2) != 0) begin : g_bad_params
    $error("keypad_encoder: DEBOUNCE_CYCLES must be >= 1 and CLK_HZ even and >= 2");
  end

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic                armed;
  logic [BCD_W-1:0]    code;
  logic                stable;
  logic                accept;

  assign code = highest_key(sync2);

`ifdef KEY_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_KEYS-1:0] sync_prev;
  logic [DBW-1:0]      db_count;
  logic [DBW-1:0]      db_next;

  // db_next counts consecutive edges, including this one, with the same nonzero sync2.
  always_comb begin
    db_next = '0;
    if (sync2 != '0) begin
      if (sync2 != sync_prev)                         db_next = DBW'(1);
      else if (db_count != DBW'(DEBOUNCE_CYCLES))     db_next = db_count + 1'b1;
      else                                            db_next = db_count;
    end
  end

  assign stable = (db_next == DBW'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_prev <= '0;
      db_count  <= '0;
    end else begin
      sync_prev <= sync2;
      db_count  <= db_next;
    end
  end
`else
  assign stable = 1'b1;
`endif

  assign accept = (sync2 != '0) && armed && !enablen && stable;

  // A key seen while disabled disarms too, so it must be released before it can count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      armed <= 1'b1;
      D     <= '0;
      loadn <= 1'b1;
    end else begin
      sync1 <= keypad;
      sync2 <= sync1;
      loadn <= ~accept;
      if (accept) D <= code;
      if (sync2 == '0)             armed <= 1'b1;
      else if (accept || enablen)  armed <= 1'b0;
    end
  end

  clk_div_1hz #(
    .CLK_HZ(CLK_HZ)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .pgt_1Hz(pgt_1Hz)
  );

endmodule

// File: tb/tb_keypad_encoder.sv
// tb/tb_keypad_encoder.sv - directed vector bench for keypad_encoder (honours KEY_DEBOUNCE_EN)
module tb_keypad_encoder;

  localparam int CLK_HZ = 50;
  localparam int DB_CYC = 3;
`ifdef KEY_DEBOUNCE_EN
  localparam int LAT = 1 + DB_CYC;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] keypad = '0;
  logic       enablen = 1'b0;
  logic [3:0] D;
  logic       loadn;
  logic       pgt_1Hz;

  int nvec = 0;
  int nerr = 0;

  keypad_encoder #(
    .CLK_HZ         (CLK_HZ),
    .DEBOUNCE_CYCLES(DB_CYC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .keypad (keypad),
    .enablen(enablen),
    .D      (D),
    .loadn  (loadn),
    .pgt_1Hz(pgt_1Hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] keys;
    logic       en;
    int         hold;
    int         pulses;
    logic [3:0] d;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic count_pulses(input int n, inout int pulses);
    for (int c = 0; c < n; c++) begin
      step();
      if (loadn === 1'b0) pulses++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int pulses;
    pulses = 0;
    keypad  = v.keys;
    enablen = v.en;
    count_pulses(v.hold, pulses);
    keypad  = '0;
    enablen = 1'b0;
    count_pulses(LAT + 3, pulses);
    check($sformatf("vec%0d pulses", idx), pulses, v.pulses);
    check($sformatf("vec%0d D", idx), int'(D), int'(v.d));
  endtask

  initial begin
    int pulses;
    int expd;

    vecs[0]  = '{10'h002, 1'b0, 5, 1, 4'd1};
    vecs[1]  = '{10'h080, 1'b1, 5, 0, 4'd1};
    vecs[2]  = '{10'h080, 1'b0, 5, 1, 4'd7};
    vecs[3]  = '{10'h104, 1'b0, 5, 1, 4'd8};
    vecs[4]  = '{10'h000, 1'b0, 3, 0, 4'd8};
    vecs[5]  = '{10'h200, 1'b0, 5, 1, 4'd9};
    vecs[6]  = '{10'h3FF, 1'b0, 5, 1, 4'd9};
    vecs[7]  = '{10'h001, 1'b0, 5, 1, 4'd0};
`ifdef KEY_DEBOUNCE_EN
    vecs[8]  = '{10'h010, 1'b0, 2, 0, 4'd0};
    vecs[9]  = '{10'h040, 1'b0, 1, 0, 4'd0};
`else
    vecs[8]  = '{10'h010, 1'b0, 2, 1, 4'd4};
    vecs[9]  = '{10'h040, 1'b0, 1, 1, 4'd6};
`endif
    vecs[10] = '{10'h008, 1'b0, 6, 1, 4'd3};
    vecs[11] = '{10'h020, 1'b1, 5, 0, 4'd3};

    // Reset values
    step();
    step();
    check("reset D", int'(D), 0);
    check("reset loadn", int'(loadn), 1);
    check("reset pgt_1Hz", int'(pgt_1Hz), 0);

    // Divider: rises at edge 25, falls at 50, rises at 75
    rst = 1'b0;
    for (int n = 1; n <= 80; n++) begin
      step();
      expd = (n / (CLK_HZ / 2)) % 2;
      check($sformatf("pgt_1Hz edge %0d", n), int'(pgt_1Hz), expd);
    end

    // Exact latency of a single press
    keypad = 10'h020;
    for (int s = 1; s <= LAT + 3; s++) begin
      step();
      check($sformatf("latency loadn step %0d", s), int'(loadn), (s == LAT + 1) ? 0 : 1);
      if (s == LAT + 1) check("latency D", int'(D), 5);
    end
    keypad = '0;
    pulses = 0;
    count_pulses(LAT + 3, pulses);
    check("latency no extra pulse", pulses, 0);
    check("D held after release", int'(D), 5);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Key held while enablen falls is ignored until re-pressed
    enablen = 1'b1;
    keypad  = 10'h080;
    pulses  = 0;
    count_pulses(5, pulses);
    enablen = 1'b0;
    count_pulses(LAT + 4, pulses);
    check("held through enable pulses", pulses, 0);
    check("held through enable D", int'(D), 3);
    keypad = '0;
    count_pulses(LAT + 2, pulses);
    keypad = 10'h080;
    count_pulses(LAT + 3, pulses);
    check("re-press pulses", pulses, 1);
    check("re-press D", int'(D), 7);
    keypad = '0;
    count_pulses(LAT + 2, pulses);

    // Adding a key while others are held
    pulses = 0;
    keypad = 10'h104;
    count_pulses(LAT + 3, pulses);
    check("multi-key pulses", pulses, 1);
    check("multi-key D", int'(D), 8);
    keypad = 10'h304;
    pulses = 0;
    count_pulses(LAT + 4, pulses);
    check("added key pulses", pulses, 0);
    check("added key D", int'(D), 8);
    keypad = '0;
    count_pulses(LAT + 2, pulses);

    // enablen rising right before the accept edge suppresses it
    pulses = 0;
    keypad = 10'h008;
    count_pulses(LAT, pulses);
    enablen = 1'b1;
    count_pulses(3, pulses);
    enablen = 1'b0;
    count_pulses(LAT + 3, pulses);
    check("enable race pulses", pulses, 0);
    check("enable race D", int'(D), 8);
    keypad = '0;
    count_pulses(LAT + 2, pulses);

    // Reset during the strobe, then the held key is accepted again
    keypad = 10'h010;
    for (int s = 0; s < LAT + 1; s++) step();
    check("pre-reset loadn", int'(loadn), 0);
    rst = 1'b1;
    #1;
    check("async reset loadn", int'(loadn), 1);
    check("async reset D", int'(D), 0);
    step();
    step();
    rst = 1'b0;
    pulses = 0;
    count_pulses(LAT + 3, pulses);
    check("post-reset pulses", pulses, 1);
    check("post-reset D", int'(D), 4);
    keypad = '0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
